// File: rtl/decode_dispatch_queue.sv
// decode_dispatch_queue: RV32I decode stage feeding an in-order dispatch queue towards RS/LSB/ROB.
// Optional DISPATCH_BYPASS_EN: an empty queue lets a legal instruction issue in the cycle it arrives.
`ifndef opTypeWidth
`define opTypeWidth 6
`endif

module decode_dispatch_queue #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    flush_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_inst,
   input  logic [ADDR_WIDTH-1:0]   in_pc,
   input  logic                    rob_idle,
   input  logic                    rs_idle,
   input  logic                    lsb_idle,
   output logic                    issue_rs,
   output logic                    issue_lsb,
   output logic [`opTypeWidth-1:0] out_op_type,
   output logic [4:0]              out_rd,
   output logic [4:0]              out_rs1,
   output logic [4:0]              out_rs2,
   output logic [31:0]             out_imm,
   output logic [ADDR_WIDTH-1:0]   out_pc,
   output logic [CNT_WIDTH-1:0]    count,
   output logic [15:0]             illegal_cnt
);
   localparam int OW    = `opTypeWidth;
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

   localparam logic [OW-1:0] OP_LUI   = OW'(1),  OP_AUIPC = OW'(2),  OP_JAL   = OW'(3),  OP_JALR  = OW'(4);
   localparam logic [OW-1:0] OP_BEQ   = OW'(5),  OP_BNE   = OW'(6),  OP_BLT   = OW'(7),  OP_BGE   = OW'(8);
   localparam logic [OW-1:0] OP_BLTU  = OW'(9),  OP_BGEU  = OW'(10), OP_LB    = OW'(11), OP_LH    = OW'(12);
   localparam logic [OW-1:0] OP_LW    = OW'(13), OP_LBU   = OW'(14), OP_LHU   = OW'(15), OP_SB    = OW'(16);
   localparam logic [OW-1:0] OP_SH    = OW'(17), OP_SW    = OW'(18), OP_ADDI  = OW'(19), OP_SLTI  = OW'(20);
   localparam logic [OW-1:0] OP_SLTIU = OW'(21), OP_XORI  = OW'(22), OP_ORI   = OW'(23), OP_ANDI  = OW'(24);
   localparam logic [OW-1:0] OP_SLLI  = OW'(25), OP_SRLI  = OW'(26), OP_SRAI  = OW'(27), OP_ADD   = OW'(28);
   localparam logic [OW-1:0] OP_SUB   = OW'(29), OP_SLL   = OW'(30), OP_SLT   = OW'(31), OP_SLTU  = OW'(32);
   localparam logic [OW-1:0] OP_XOR   = OW'(33), OP_SRL   = OW'(34), OP_SRA   = OW'(35), OP_OR    = OW'(36);
   localparam logic [OW-1:0] OP_AND   = OW'(37);

   typedef struct packed {
      logic                  is_ls;
      logic [OW-1:0]         op;
      logic [4:0]            rd;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [31:0]           imm;
      logic [ADDR_WIDTH-1:0] pc;
   } entry_t;

   entry_t               r_mem [DEPTH];
   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     r_tail;
   logic [CNT_WIDTH-1:0] r_count;
   logic [15:0]          r_illegal;

   entry_t      w_dec;
   entry_t      w_head;
   entry_t      w_out;
   logic        w_legal;
   logic [2:0]  w_f3;
   logic        w_alt;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_imm_sh;

   assign w_f3     = in_inst[14:12];
   assign w_alt    = in_inst[30];
   assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
   assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
   assign w_imm_u  = {in_inst[31:12], 12'b0};
   assign w_imm_sh = {27'b0, in_inst[24:20]};

   // Register fields start raw and are zeroed per format where the operand does not exist.
   always_comb begin
      w_dec     = '0;
      w_legal   = 1'b1;
      w_dec.pc  = in_pc;
      w_dec.rd  = in_inst[11:7];
      w_dec.rs1 = in_inst[19:15];
      w_dec.rs2 = in_inst[24:20];
      case (in_inst[6:0])
         7'b0110111: begin w_dec.op = OP_LUI;   w_dec.imm = w_imm_u; w_dec.rs1 = '0; w_dec.rs2 = '0; end
         7'b0010111: begin w_dec.op = OP_AUIPC; w_dec.imm = w_imm_u; w_dec.rs1 = '0; w_dec.rs2 = '0; end
         7'b1101111: begin w_dec.op = OP_JAL;   w_dec.imm = w_imm_j; w_dec.rs1 = '0; w_dec.rs2 = '0; end
         7'b1100111: begin
            w_dec.op  = OP_JALR;
            w_dec.imm = w_imm_i;
            w_dec.rs2 = '0;
            w_legal   = (w_f3 == 3'd0);
         end
         7'b1100011: begin
            w_dec.imm = w_imm_b;
            w_dec.rd  = '0;
            case (w_f3)
               3'd0: w_dec.op = OP_BEQ;
               3'd1: w_dec.op = OP_BNE;
               3'd4: w_dec.op = OP_BLT;
               3'd5: w_dec.op = OP_BGE;
               3'd6: w_dec.op = OP_BLTU;
               3'd7: w_dec.op = OP_BGEU;
               default: w_legal = 1'b0;
            endcase
         end
         7'b0000011: begin
            w_dec.is_ls = 1'b1;
            w_dec.imm   = w_imm_i;
            w_dec.rs2   = '0;
            case (w_f3)
               3'd0: w_dec.op = OP_LB;
               3'd1: w_dec.op = OP_LH;
               3'd2: w_dec.op = OP_LW;
               3'd4: w_dec.op = OP_LBU;
               3'd5: w_dec.op = OP_LHU;
               default: w_legal = 1'b0;
            endcase
         end
         7'b0100011: begin
            w_dec.is_ls = 1'b1;
            w_dec.imm   = w_imm_s;
            w_dec.rd    = '0;
            case (w_f3)
               3'd0: w_dec.op = OP_SB;
               3'd1: w_dec.op = OP_SH;
               3'd2: w_dec.op = OP_SW;
               default: w_legal = 1'b0;
            endcase
         end
         7'b0010011: begin
            w_dec.imm = w_imm_i;
            w_dec.rs2 = '0;
            case (w_f3)
               3'd0: w_dec.op = OP_ADDI;
               3'd1: begin w_dec.op = OP_SLLI; w_dec.imm = w_imm_sh; end
               3'd2: w_dec.op = OP_SLTI;
               3'd3: w_dec.op = OP_SLTIU;
               3'd4: w_dec.op = OP_XORI;
               3'd5: begin w_dec.op = w_alt ? OP_SRAI : OP_SRLI; w_dec.imm = w_imm_sh; end
               3'd6: w_dec.op = OP_ORI;
               default: w_dec.op = OP_ANDI;
            endcase
         end
         7'b0110011: begin
            w_dec.imm = '0;
            case (w_f3)
               3'd0: w_dec.op = w_alt ? OP_SUB : OP_ADD;
               3'd1: w_dec.op = OP_SLL;
               3'd2: w_dec.op = OP_SLT;
               3'd3: w_dec.op = OP_SLTU;
               3'd4: w_dec.op = OP_XOR;
               3'd5: w_dec.op = w_alt ? OP_SRA : OP_SRL;
               3'd6: w_dec.op = OP_OR;
               default: w_dec.op = OP_AND;
            endcase
         end
         default: w_legal = 1'b0;
      endcase
   end

   logic w_nonempty, w_can_rs, w_can_lsb, w_accept;
   logic w_q_rs, w_q_lsb, w_byp_rs, w_byp_lsb, w_bypass, w_enq, w_deq, w_illegal;

   assign w_head     = r_mem[r_head];
   assign w_nonempty = (r_count != '0);
   assign in_ready   = rst_in & rdy_in & ~flush_in & (r_count != FULL_CNT);
   assign w_accept   = in_valid & in_ready;
   assign w_can_rs   = rst_in & rdy_in & ~flush_in & rob_idle & rs_idle;
   assign w_can_lsb  = rst_in & rdy_in & ~flush_in & rob_idle & lsb_idle;
   assign w_q_rs     = w_nonempty & ~w_head.is_ls & w_can_rs;
   assign w_q_lsb    = w_nonempty & w_head.is_ls & w_can_lsb;

`ifdef DISPATCH_BYPASS_EN
   assign w_byp_rs   = w_accept & w_legal & ~w_nonempty & ~w_dec.is_ls & w_can_rs;
   assign w_byp_lsb  = w_accept & w_legal & ~w_nonempty & w_dec.is_ls & w_can_lsb;
`else
   assign w_byp_rs   = 1'b0;
   assign w_byp_lsb  = 1'b0;
`endif

   assign w_bypass  = w_byp_rs | w_byp_lsb;
   assign w_enq     = w_accept & w_legal & ~w_bypass;
   assign w_deq     = w_q_rs | w_q_lsb;
   assign w_illegal = w_accept & ~w_legal;
   assign w_out     = w_bypass ? w_dec : w_head;

   assign issue_rs    = w_q_rs | w_byp_rs;
   assign issue_lsb   = w_q_lsb | w_byp_lsb;
   assign out_op_type = w_out.op;
   assign out_rd      = w_out.rd;
   assign out_rs1     = w_out.rs1;
   assign out_rs2     = w_out.rs2;
   assign out_imm     = w_out.imm;
   assign out_pc      = w_out.pc;
   assign count       = r_count;
   assign illegal_cnt = r_illegal;

   always_ff @(posedge clk_in) begin
      if (w_enq) r_mem[r_tail] <= w_dec;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_illegal <= '0;
      end else if (flush_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy_in) begin
         if (w_enq) r_tail <= r_tail + PTR_W'(1);
         if (w_deq) r_head <= r_head + PTR_W'(1);
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + CNT_WIDTH'(1);
            2'b01:   r_count <= r_count - CNT_WIDTH'(1);
            default: r_count <= r_count;
         endcase
         if (w_illegal && (r_illegal != '1)) r_illegal <= r_illegal + 16'd1;
      end
   end
endmodule
